// File: rtl/checkers_row_sweep_ctrl_if.sv
// Avalon-style write bus into the bank of row-output PIO slaves.
// Master drives one-hot chipselect, active-low write strobe, register address and data.
interface checkers_row_sweep_ctrl_if #(
    parameter int unsigned NumRows = 8
);
    logic [NumRows-1:0] chipselect;
    logic               write_n;
    logic [2:0]         address;
    logic [31:0]        writedata;

    modport master (
        output chipselect,
        output write_n,
        output address,
        output writedata
    );

    modport slave (
        input chipselect,
        input write_n,
        input address,
        input writedata
    );
endinterface

// File: rtl/checkers_row_sweep_ctrl.sv
// Sweeps a buffered checkers board image into the row PIOs, one write per row
// (full overwrite at address 0) or set/clear pairs (addresses 4/5) in masked mode.
module checkers_row_sweep_ctrl #(
    parameter int unsigned NumRows = 8,
    parameter int unsigned Gap     = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              load_en_i,
    input  logic [2:0]                        load_row_i,
    input  logic [31:0]                       load_data_i,
    input  logic [31:0]                       load_mask_i,
    input  logic                              start_i,
    input  logic                              mode_i,
    output logic                              busy_o,
    output logic                              done_o,
    checkers_row_sweep_ctrl_if.master         pio
);

    typedef enum logic [2:0] {StIdle, StFull, StSet, StClr, StGapWait, StDone} state_e;

    localparam logic [2:0] LastRow = 3'(NumRows - 1);
    localparam bit         GapOn   = (Gap != 0);
    localparam logic [3:0] GapLoad = 4'(Gap - 1);

    state_e             state_q;
    logic [2:0]         row_q;
    logic               mode_q;
    logic [3:0]         gap_cnt_q;
    logic               from_set_q;
    logic [31:0]        data_q [8];
    logic [31:0]        mask_q [8];

    logic               busy_q, done_q, wr_n_q;
    logic [NumRows-1:0] cs_q;
    logic [2:0]         addr_q;
    logic [31:0]        wdata_q;

    logic               idle_load;
    logic [2:0]         enter_idx;
    logic [31:0]        enter_data, enter_mask, enter_set, enter_word;
    logic               enter_mode, enter_strobe;
    logic [2:0]         enter_addr;
    logic [31:0]        cur_clr;
    logic               strobed, adv, enter;

    function automatic logic [NumRows-1:0] row_sel(input logic [2:0] r);
        return NumRows'(1) << r;
    endfunction

    assign idle_load = (state_q == StIdle) && load_en_i && (32'(load_row_i) < NumRows);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else if (idle_load) begin
            data_q[load_row_i] <= load_data_i;
            mask_q[load_row_i] <= load_mask_i;
        end
    end

    // Row about to be entered: row 0 on start (with same-cycle load bypass), else row_q+1.
    always_comb begin
        enter_idx  = (state_q == StIdle) ? 3'd0 : row_q + 3'd1;
        enter_data = data_q[enter_idx];
        enter_mask = mask_q[enter_idx];
        if (idle_load && (load_row_i == 3'd0)) begin
            enter_data = load_data_i;
            enter_mask = load_mask_i;
        end
        enter_mode   = (state_q == StIdle) ? mode_i : mode_q;
        enter_set    = enter_data & enter_mask;
        enter_strobe = enter_mode ? (enter_set != 32'd0) : 1'b1;
        enter_addr   = enter_mode ? 3'd4 : 3'd0;
        enter_word   = enter_mode ? enter_set : enter_data;
        cur_clr      = ~data_q[row_q] & mask_q[row_q];
    end

    assign strobed = !wr_n_q;
    assign adv = ((state_q == StFull) && !GapOn)
              || ((state_q == StClr) && !(strobed && GapOn))
              || ((state_q == StGapWait) && (gap_cnt_q == 4'd0) && !from_set_q);
    assign enter = ((state_q == StIdle) && start_i) || (adv && (row_q != LastRow));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            row_q      <= '0;
            mode_q     <= 1'b0;
            gap_cnt_q  <= '0;
            from_set_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_q       <= '0;
            wr_n_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            cs_q    <= '0;
            wr_n_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            if ((state_q == StIdle) && start_i) begin
                mode_q <= mode_i;
                busy_q <= 1'b1;
            end
            if (enter) begin
                state_q <= enter_mode ? StSet : StFull;
                row_q   <= enter_idx;
                if (enter_strobe) begin
                    cs_q    <= row_sel(enter_idx);
                    wr_n_q  <= 1'b0;
                    addr_q  <= enter_addr;
                    wdata_q <= enter_word;
                end
            end else if (adv) begin
                state_q <= StDone;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    StFull, StClr: begin
                        state_q    <= StGapWait;
                        gap_cnt_q  <= GapLoad;
                        from_set_q <= 1'b0;
                    end
                    StSet: begin
                        if (strobed && GapOn) begin
                            state_q    <= StGapWait;
                            gap_cnt_q  <= GapLoad;
                            from_set_q <= 1'b1;
                        end else begin
                            state_q <= StClr;
                            if (cur_clr != 32'd0) begin
                                cs_q    <= row_sel(row_q);
                                wr_n_q  <= 1'b0;
                                addr_q  <= 3'd5;
                                wdata_q <= cur_clr;
                            end
                        end
                    end
                    StGapWait: begin
                        if (gap_cnt_q != 4'd0) begin
                            gap_cnt_q <= gap_cnt_q - 4'd1;
                        end else begin
                            // Only reached after a SET gap; the clear half of the row follows.
                            state_q <= StClr;
                            if (cur_clr != 32'd0) begin
                                cs_q    <= row_sel(row_q);
                                wr_n_q  <= 1'b0;
                                addr_q  <= 3'd5;
                                wdata_q <= cur_clr;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pio.chipselect = cs_q;
    assign pio.write_n    = wr_n_q;
    assign pio.address    = addr_q;
    assign pio.writedata  = wdata_q;

endmodule

// File: tb/tb_checkers_row_sweep_ctrl.sv
// Directed bench: two sweepers (GAP=0 and GAP=2) share stimulus; every output is packed
// into one vector per cycle and compared against hand-derived schedules.
module tb_checkers_row_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en, start, mode;
    logic [2:0]  load_row;
    logic [31:0] load_data, load_mask;
    logic        busy0, done0, busy2, done2;

    int          tests, fails;
    logic [31:0] exp_data [8];

    checkers_row_sweep_ctrl_if #(.NumRows(8)) pio0 ();
    checkers_row_sweep_ctrl_if #(.NumRows(8)) pio2 ();

    checkers_row_sweep_ctrl #(.NumRows(8), .Gap(0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .load_en_i(load_en), .load_row_i(load_row),
        .load_data_i(load_data), .load_mask_i(load_mask), .start_i(start), .mode_i(mode),
        .busy_o(busy0), .done_o(done0), .pio(pio0.master)
    );

    checkers_row_sweep_ctrl #(.NumRows(8), .Gap(2)) u_gap (
        .clk_i(clk), .rst_ni(rst_n), .load_en_i(load_en), .load_row_i(load_row),
        .load_data_i(load_data), .load_mask_i(load_mask), .start_i(start), .mode_i(mode),
        .busy_o(busy2), .done_o(done2), .pio(pio2.master)
    );

    always #5 clk = ~clk;

    function automatic logic [45:0] ev(input bit busy, input bit done, input bit stb,
                                       input int row, input logic [2:0] addr,
                                       input logic [31:0] data);
        logic [7:0] cs;
        cs = 8'd1 << row;
        if (stb) return {busy, done, cs, 1'b0, addr, data};
        return {busy, done, 8'h00, 1'b1, 3'd0, 32'd0};
    endfunction

    function automatic logic [45:0] obs0();
        return {busy0, done0, pio0.chipselect, pio0.write_n, pio0.address, pio0.writedata};
    endfunction

    function automatic logic [45:0] obs2();
        return {busy2, done2, pio2.chipselect, pio2.write_n, pio2.address, pio2.writedata};
    endfunction

    // Full mode, GAP=0: strobe row c-1 in cycles 1..8, done in 9.
    function automatic logic [45:0] exp_full0(input int c);
        if (c >= 1 && c <= 8) return ev(1, 0, 1, c - 1, 3'd0, exp_data[c-1]);
        if (c == 9) return ev(1, 1, 0, 0, 3'd0, 32'd0);
        return ev(0, 0, 0, 0, 3'd0, 32'd0);
    endfunction

    // Full mode, GAP=2: strobe at 1,4,...,22, done at 25.
    function automatic logic [45:0] exp_full2(input int c);
        if (c >= 1 && c <= 24) begin
            if ((c - 1) % 3 == 0) return ev(1, 0, 1, (c - 1) / 3, 3'd0, exp_data[(c-1)/3]);
            return ev(1, 0, 0, 0, 3'd0, 32'd0);
        end
        if (c == 25) return ev(1, 1, 0, 0, 3'd0, 32'd0);
        return ev(0, 0, 0, 0, 3'd0, 32'd0);
    endfunction

    // Masked, only row 2 has mask 0x0000FFFF and data 0x0000F0F0.
    function automatic logic [45:0] exp_mask0(input int c);
        if (c == 5) return ev(1, 0, 1, 2, 3'd4, 32'h0000F0F0);
        if (c == 6) return ev(1, 0, 1, 2, 3'd5, 32'h00000F0F);
        if (c >= 1 && c <= 16) return ev(1, 0, 0, 0, 3'd0, 32'd0);
        if (c == 17) return ev(1, 1, 0, 0, 3'd0, 32'd0);
        return ev(0, 0, 0, 0, 3'd0, 32'd0);
    endfunction

    function automatic logic [45:0] exp_mask2(input int c);
        if (c == 5) return ev(1, 0, 1, 2, 3'd4, 32'h0000F0F0);
        if (c == 8) return ev(1, 0, 1, 2, 3'd5, 32'h00000F0F);
        if (c >= 1 && c <= 20) return ev(1, 0, 0, 0, 3'd0, 32'd0);
        if (c == 21) return ev(1, 1, 0, 0, 3'd0, 32'd0);
        return ev(0, 0, 0, 0, 3'd0, 32'd0);
    endfunction

    task automatic chk(input string tag, input logic [45:0] obs, input logic [45:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int row, input logic [31:0] data, input logic [31:0] mask);
        load_en   = 1'b1;
        load_row  = 3'(row);
        load_data = data;
        load_mask = mask;
        exp_data[row] = data;
        step();
        load_en = 1'b0;
    endtask

    // Full-mode sweep on both instances. ld0: load row 0 with start. inj: start+load at
    // cycle 3 while busy. b2b: restart u_dut the cycle after its done pulse.
    task automatic run_full(input bit ld0, input bit inj, input bit b2b, input string name);
        int cd;
        start = 1'b1;
        mode  = 1'b0;
        if (ld0) begin
            load_en   = 1'b1;
            load_row  = 3'd0;
            load_data = 32'hDEADBEEF;
            load_mask = 32'd0;
            exp_data[0] = 32'hDEADBEEF;
        end
        step();
        start   = 1'b0;
        load_en = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            cd = (b2b && c >= 11) ? c - 10 : c;
            chk($sformatf("%s g0 c%0d", name, c), obs0(), exp_full0(cd));
            chk($sformatf("%s g2 c%0d", name, c), obs2(), exp_full2(c));
            if (inj && c == 3) begin
                start     = 1'b1;
                load_en   = 1'b1;
                load_row  = 3'd5;
                load_data = 32'hAAAAAAAA;
                load_mask = 32'hFFFFFFFF;
            end
            if (b2b && c == 10) start = 1'b1;
            step();
            start   = 1'b0;
            load_en = 1'b0;
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        load_en   = 1'b0;
        load_row  = 3'd0;
        load_data = 32'd0;
        load_mask = 32'd0;
        start     = 1'b0;
        mode      = 1'b0;
        for (int i = 0; i < 8; i++) exp_data[i] = 32'd0;

        #12;
        chk("reset g0", obs0(), ev(0, 0, 0, 0, 3'd0, 32'd0));
        chk("reset g2", obs2(), ev(0, 0, 0, 0, 3'd0, 32'd0));
        step();
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) load(r, 32'(32'h11111111 * r), 32'd0);
        run_full(0, 0, 0, "full");

        load(2, 32'h0000F0F0, 32'h0000FFFF);
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            chk($sformatf("mask g0 c%0d", c), obs0(), exp_mask0(c));
            chk($sformatf("mask g2 c%0d", c), obs2(), exp_mask2(c));
            step();
        end

        run_full(0, 1, 0, "busyinj");
        run_full(0, 0, 1, "b2b");
        run_full(1, 0, 0, "ldstart");

        start = 1'b1;
        mode  = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("prereset c4 g0", obs0(), exp_full0(4));
        rst_n = 1'b0;
        #1;
        chk("midreset g0", obs0(), ev(0, 0, 0, 0, 3'd0, 32'd0));
        chk("midreset g2", obs2(), ev(0, 0, 0, 0, 3'd0, 32'd0));
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) exp_data[i] = 32'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("postreset g0 k%0d", k), obs0(), ev(0, 0, 0, 0, 3'd0, 32'd0));
            chk($sformatf("postreset g2 k%0d", k), obs2(), ev(0, 0, 0, 0, 3'd0, 32'd0));
        end
        run_full(0, 0, 0, "zeros");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
